f2d_ff: RTL and testbench

- Fetch-to-decode pipeline register; sits directly upstream of the decode stage, which feeds the decode/execute register.
- Captures instruction and incremented PC from fetch.
- Has a one-entry skid buffer so an instruction returned by the stalling instruction memory is never lost while decode stalls.
- Handles decode stall, branch/jump flush (NOP injection) and back-pressure to fetch.

---
 rtl/f2d_pkg.sv | 25 ++
 rtl/f2d_skid_buf.sv | 53 +++++
 rtl/f2d_ff.sv | 192 +++++++++++++++++++
 tb/tb_f2d_ff.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/f2d_pkg.sv
// ---------------------------------------------------------------------------
// f2d_pkg
// Shared pipeline package for the fetch-to-decode register slice.
//
// Contents:
//   F2D_DATA_W    - default width of instruction and PC words
//   F2D_NOP_INSTR - encoding shown to decode when the stage holds nothing
//   f2dState_t    - occupancy state of the fetch-to-decode stage
//
// Optional feature macro used by the slice: F2D_PERF_EN (perf counters).
// ---------------------------------------------------------------------------
package f2d_pkg;

    localparam int          F2D_DATA_W    = 16;
    localparam logic [15:0] F2D_NOP_INSTR = 16'h0800;

    // EMPTY: nothing for decode; FULL: main entry valid, skid empty;
    // SKID: main and skid entries both valid, fetch is being held.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } f2dState_t;

endpackage : f2d_pkg

// File: rtl/f2d_skid_buf.sv
// ---------------------------------------------------------------------------
// f2d_skid_buf
// One-entry {instr, incPC, valid} register used for both the main and the
// skid slot of the fetch-to-decode stage.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   load     in   capture instrIn/incPCIn and mark the entry valid
//   clear    in   invalidate the entry (wins over load)
//   instrIn  in   DATA_W  instruction to capture
//   incPCIn  in   DATA_W  PC+2 to capture
//   instr    out  DATA_W  stored instruction (NOP_INSTR when invalid)
//   incPC    out  DATA_W  stored PC+2
//   valid    out  entry holds a real instruction
// With neither load nor clear asserted the entry holds.
// ---------------------------------------------------------------------------
module f2d_skid_buf
    import f2d_pkg::*;
#(
    parameter int                DATA_W    = F2D_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(F2D_NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] instrIn,
    input  logic [DATA_W-1:0] incPCIn,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] incPC,
    output logic              valid
);

    // Clearing swaps the instruction for the NOP encoding so an invalid
    // entry never shows stale data downstream. The PC word is deliberately
    // left alone on clear: after a squash decode keeps seeing the last PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr <= NOP_INSTR;
            incPC <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instrIn;
            incPC <= incPCIn;
            valid <= 1'b1;
        end
    end

endmodule : f2d_skid_buf

// File: rtl/f2d_ff.sv
// ---------------------------------------------------------------------------
// f2d_ff
// Fetch-to-decode pipeline register with a one-entry skid buffer. An
// instruction returned by instruction memory in the same cycle decode
// stalls is parked in the skid slot instead of being dropped; fetch is then
// held (stallF) until decode drains the stage. flushD squashes everything.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   instrF       in   DATA_W  instruction from instruction memory
//   incPCF       in   DATA_W  PC+2 of that instruction
//   fetchValidF  in   instrF/incPCF valid this cycle
//   stallD       in   decode cannot advance this cycle
//   flushD       in   squash stage contents (taken branch/jump)
//   instructionD out  DATA_W  instruction to decode (NOP_INSTR when invalid)
//   incPCD       out  DATA_W  PC+2 to decode
//   validD       out  instructionD is a real instruction
//   stallF       out  fetch must hold its PC and re-present instrF
//   stallCntP    out  16  perf: cycles with validD & stallD
//   bubbleCntP   out  16  perf: cycles with validD low
//
// Build option: define F2D_PERF_EN to implement the saturating perf
// counters; without it both counter ports read 16'h0000.
// ---------------------------------------------------------------------------
module f2d_ff
    import f2d_pkg::*;
#(
    parameter int                DATA_W    = F2D_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(F2D_NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instrF,
    input  logic [DATA_W-1:0] incPCF,
    input  logic              fetchValidF,
    input  logic              stallD,
    input  logic              flushD,
    output logic [DATA_W-1:0] instructionD,
    output logic [DATA_W-1:0] incPCD,
    output logic              validD,
    output logic              stallF,
    output logic [15:0]       stallCntP,
    output logic [15:0]       bubbleCntP
);

    f2dState_t         state;
    f2dState_t         nextState;
    logic              accept;
    logic              mainLoad;
    logic              mainClear;
    logic              mainFromSkid;
    logic              skidLoad;
    logic              skidClear;
    logic [DATA_W-1:0] mainInstrIn;
    logic [DATA_W-1:0] mainIncPCIn;
    logic [DATA_W-1:0] skidInstr;
    logic [DATA_W-1:0] skidIncPC;
    logic              skidValid;

    // stallF comes purely from registered state so fetch never sees a
    // combinational path from the hazard unit's stallD.
    assign stallF = (state == SKID);
    assign accept = fetchValidF & ~stallF;

    // The main slot is refilled either straight from fetch or, when a
    // parked instruction is released, from the skid slot.
    assign mainInstrIn = mainFromSkid ? skidInstr : instrF;
    assign mainIncPCIn = mainFromSkid ? skidIncPC : incPCF;

    f2d_skid_buf #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) mainBuf (
        .clk     (clk),
        .rst     (rst),
        .load    (mainLoad),
        .clear   (mainClear),
        .instrIn (mainInstrIn),
        .incPCIn (mainIncPCIn),
        .instr   (instructionD),
        .incPC   (incPCD),
        .valid   (validD)
    );

    f2d_skid_buf #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) skidBuf (
        .clk     (clk),
        .rst     (rst),
        .load    (skidLoad),
        .clear   (skidClear),
        .instrIn (instrF),
        .incPCIn (incPCF),
        .instr   (skidInstr),
        .incPC   (skidIncPC),
        .valid   (skidValid)
    );

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and slot control. A flush beats everything, including an
    // accept in the same cycle, so a squashed fetch never reaches decode.
    // In EMPTY stallD is irrelevant: there is nothing to hold, so a new
    // instruction may always be captured. In FULL with decode stalled, an
    // arriving instruction is parked in the skid slot, which raises stallF
    // for the next cycle so fetch stops returning new words.
    always_comb begin
        nextState    = state;
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;

        if (flushD) begin
            nextState = EMPTY;
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        mainLoad  = 1'b1;
                        nextState = FULL;
                    end
                end
                FULL: begin
                    if (!stallD) begin
                        if (accept) begin
                            mainLoad = 1'b1;
                        end else begin
                            mainClear = 1'b1;
                            nextState = EMPTY;
                        end
                    end else if (accept) begin
                        skidLoad  = 1'b1;
                        nextState = SKID;
                    end
                end
                SKID: begin
                    if (!stallD) begin
                        mainLoad     = skidValid;
                        mainFromSkid = 1'b1;
                        skidClear    = 1'b1;
                        nextState    = FULL;
                    end
                end
                default: begin
                    nextState = EMPTY;
                    mainClear = 1'b1;
                    skidClear = 1'b1;
                end
            endcase
        end
    end

`ifdef F2D_PERF_EN
    logic [15:0] stallCnt;
    logic [15:0] bubbleCnt;

    // Saturating perf counters; only reset clears them, a flush does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt  <= 16'h0000;
            bubbleCnt <= 16'h0000;
        end else begin
            if (validD && stallD && (stallCnt != 16'hFFFF)) begin
                stallCnt <= stallCnt + 16'h0001;
            end
            if (!validD && (bubbleCnt != 16'hFFFF)) begin
                bubbleCnt <= bubbleCnt + 16'h0001;
            end
        end
    end

    assign stallCntP  = stallCnt;
    assign bubbleCntP = bubbleCnt;
`else
    assign stallCntP  = 16'h0000;
    assign bubbleCntP = 16'h0000;
`endif

endmodule : f2d_ff

// File: tb/tb_f2d_ff.sv
// ---------------------------------------------------------------------------
// tb_f2d_ff
// Self-checking bench for f2d_ff. The reference treats the stage as a FIFO
// of at most two instructions: decode consumes the head when not stalled,
// fetch appends when the FIFO is not full, a flush empties it.
// ---------------------------------------------------------------------------
module tb_f2d_ff;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instrF = 16'h0000;
    logic [15:0] incPCF = 16'h0000;
    logic        fetchValidF = 1'b0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic [15:0] instructionD;
    logic [15:0] incPCD;
    logic        validD;
    logic        stallF;
    logic [15:0] stallCntP;
    logic [15:0] bubbleCntP;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] modelQ[$];
    logic [15:0] modelLastPc = 16'h0000;
    int          modelStall  = 0;
    int          modelBubble = 0;

    f2d_ff dut (
        .clk          (clk),
        .rst          (rst),
        .instrF       (instrF),
        .incPCF       (incPCF),
        .fetchValidF  (fetchValidF),
        .stallD       (stallD),
        .flushD       (flushD),
        .instructionD (instructionD),
        .incPCD       (incPCD),
        .validD       (validD),
        .stallF       (stallF),
        .stallCntP    (stallCntP),
        .bubbleCntP   (bubbleCntP)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] expInstr();
        return (modelQ.size() > 0) ? modelQ[0][31:16] : 16'h0800;
    endfunction

    function automatic logic [15:0] expPc();
        return (modelQ.size() > 0) ? modelQ[0][15:0] : modelLastPc;
    endfunction

    function automatic logic [15:0] expStallCnt();
`ifdef F2D_PERF_EN
        return modelStall[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [15:0] expBubbleCnt();
`ifdef F2D_PERF_EN
        return modelBubble[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic modelReset();
        modelQ.delete();
        modelLastPc = 16'h0000;
        modelStall  = 0;
        modelBubble = 0;
    endtask

    // Advance the reference by one rising edge using the inputs that were
    // stable across that edge.
    task automatic modelStep();
        logic acc;
        if (!rst) return;
        if (modelQ.size() > 0 && stallD && modelStall < 65535) modelStall++;
        if (modelQ.size() == 0 && modelBubble < 65535) modelBubble++;
        acc = fetchValidF && (modelQ.size() < 2);
        if (flushD) begin
            modelQ.delete();
        end else begin
            if (modelQ.size() > 0 && !stallD) void'(modelQ.pop_front());
            if (acc) modelQ.push_back({instrF, incPCF});
        end
        if (modelQ.size() > 0) modelLastPc = modelQ[0][15:0];
    endtask

    task automatic checkOutput();
        checkVal("instructionD", instructionD, expInstr());
        checkVal("incPCD", incPCD, expPc());
        checkVal("validD", 16'(validD), 16'(modelQ.size() > 0));
        checkVal("stallF", 16'(stallF), 16'(modelQ.size() == 2));
        checkVal("stallCntP", stallCntP, expStallCnt());
        checkVal("bubbleCntP", bubbleCntP, expBubbleCnt());
    endtask

    // One clock cycle: check outputs mid-cycle, drive new inputs, take the
    // edge, step the model, then settle 1 time unit past the edge.
    task automatic applyStimulus(input logic fv, input logic sd, input logic fd,
                                 input logic [15:0] ins, input logic [15:0] pc);
        @(negedge clk);
        checkOutput();
        fetchValidF = fv;
        stallD      = sd;
        flushD      = fd;
        instrF      = ins;
        incPCF      = pc;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] curInstr;
        logic [15:0] curPc;
        logic        fv;
        logic        sd;
        logic        fd;

        modelReset();

        // Power-up reset, released just after an edge.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2 rst = 1'b1;
        #1;
        checkVal("rstInstr", instructionD, 16'h0800);
        checkVal("rstValid", 16'(validD), 16'h0000);
        checkVal("rstStallF", 16'(stallF), 16'h0000);
        checkVal("rstIncPC", incPCD, 16'h0000);

        // First capture plus perf-counter pinning: two bubbles then three
        // stalled cycles holding C123.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hC123, 16'h0002);
        checkVal("firstInstr", instructionD, 16'hC123);
        checkVal("firstPc", incPCD, 16'h0002);
        checkVal("firstValid", 16'(validD), 16'h0001);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        checkVal("heldInstr", instructionD, 16'hC123);
`ifdef F2D_PERF_EN
        checkVal("perfStall", stallCntP, 16'd3);
        checkVal("perfBubble", bubbleCntP, 16'd2);
`else
        checkVal("perfStallOff", stallCntP, 16'h0000);
        checkVal("perfBubbleOff", bubbleCntP, 16'h0000);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Back-to-back stream, one-cycle latency, no bubbles.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h4001, 16'h0010);
        checkVal("streamA", instructionD, 16'h4001);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h4002, 16'h0012);
        checkVal("streamB", instructionD, 16'h4002);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h4003, 16'h0014);
        checkVal("streamC", instructionD, 16'h4003);
        checkVal("streamValid", 16'(validD), 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Skid: hold A under stall while B arrives, then release.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h4001, 16'h0020);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h4002, 16'h0022);
        checkVal("skidStallF", 16'(stallF), 16'h0001);
        checkVal("skidHoldA", instructionD, 16'h4001);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h4003, 16'h0024);
        checkVal("skidReleaseB", instructionD, 16'h4002);
        checkVal("skidReleasePc", incPCD, 16'h0022);
        checkVal("skidStallFLow", 16'(stallF), 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h4003, 16'h0024);
        checkVal("skidThenC", instructionD, 16'h4003);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Flush from FULL with a simultaneous accept: accept is discarded.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h5001, 16'h0030);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h5002, 16'h0032);
        checkVal("flushValid", 16'(validD), 16'h0000);
        checkVal("flushInstr", instructionD, 16'h0800);
        checkVal("flushPcHold", incPCD, 16'h0030);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Flush while in SKID with decode stalled.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h6001, 16'h0040);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h6002, 16'h0042);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h6003, 16'h0044);
        checkVal("skidFlushValid", 16'(validD), 16'h0000);
        checkVal("skidFlushInstr", instructionD, 16'h0800);
        checkVal("skidFlushStallF", 16'(stallF), 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Asynchronous reset mid-stream while in SKID.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h7001, 16'h0050);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h7002, 16'h0052);
        checkVal("preResetStallF", 16'(stallF), 16'h0001);
        #2 rst = 1'b0;
        #1;
        checkVal("asyncRstInstr", instructionD, 16'h0800);
        checkVal("asyncRstValid", 16'(validD), 16'h0000);
        checkVal("asyncRstStallF", 16'(stallF), 16'h0000);
        checkVal("asyncRstPc", incPCD, 16'h0000);
        modelReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h7003, 16'h0054);
        #2 rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkVal("postRstValid", 16'(validD), 16'h0000);
        checkVal("postRstStallF", 16'(stallF), 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h7004, 16'h0056);
        checkVal("postRstLoad", instructionD, 16'h7004);

        // Randomized traffic; fetch re-presents the same word while stalled.
        curInstr = 16'h1000;
        curPc    = 16'h0100;
        for (int i = 0; i < 3000; i++) begin
            if (modelQ.size() < 2) begin
                curInstr = 16'($urandom_range(0, 16'hFFFF));
                curPc    = curPc + 16'h0002;
            end
            fv = ($urandom_range(0, 9) < 7);
            sd = ($urandom_range(0, 9) < 3);
            fd = ($urandom_range(0, 19) == 0);
            applyStimulus(fv, sd, fd, curInstr, curPc);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule : tb_f2d_ff
